// File: rtl/controls_pipeline_pkg.sv
// Shared state encodings, control-output bundles and helpers for controls_pipeline_gen2.
package controls_pipeline_pkg;

    typedef enum logic [2:0] {
        StReset             = 3'd0,
        StWait              = 3'd1,
        StUploadData        = 3'd2,
        StReadMemory        = 3'd3,
        StProcessing        = 3'd4,
        StRefreshInstMemory = 3'd5,
        StStepReset         = 3'd6,
        StStepProcessing    = 3'd7
    } state_e;

    typedef struct packed {
        logic wr_memory_fg;
        logic memory_fg_selector;
        logic wr_register;
        logic registers_reset;
        logic reset_counter_x;
    } ctrl_t;

    localparam ctrl_t CtrlReset   = 5'b00000;
    localparam ctrl_t CtrlSeq     = 5'b01010;
    localparam ctrl_t CtrlUpload  = 5'b01110;
    localparam ctrl_t CtrlProcess = 5'b01011;
    localparam ctrl_t CtrlRefresh = 5'b10000;

    // Never returns less than 1 so single-entry fields stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic ctrl_t ctrl_of(input state_e s);
        case (s)
            StStepReset, StReadMemory,
            StStepProcessing, StWait:  return CtrlSeq;
            StUploadData:              return CtrlUpload;
            StProcessing:              return CtrlProcess;
            StRefreshInstMemory:       return CtrlRefresh;
            default:                   return CtrlReset;
        endcase
    endfunction

endpackage

// File: rtl/lane_counter.sv
// Modulo-NUM_LANES counter with clear, hold and enable; drives the register-bank read lane.
module lane_counter
    import controls_pipeline_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    localparam int unsigned RA_W = clog2(NUM_LANES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            hold,
    input  logic            enable,
    output logic [RA_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (hold) begin
            count <= count;
        end else if (enable) begin
            count <= (count == RA_W'(NUM_LANES - 1)) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/controls_pipeline_gen2.sv
// Co-processor control sequencer: per-frame register reset, instruction load, lane stepping.
// Optional macro FRAME_CNT_EN adds a 16-bit frame_count output.
module controls_pipeline_gen2
    import controls_pipeline_pkg::*;
#(
    parameter int unsigned INST_DEPTH = 16,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned H_START    = 10,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_LAST     = 523,
    parameter int unsigned CNT_W      = 10,
    localparam int unsigned IA_W = clog2(INST_DEPTH),
    localparam int unsigned RA_W = clog2(NUM_LANES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             printtingScreen,
    input  logic             hold,
    input  logic [CNT_W-1:0] counter_x,
    input  logic [CNT_W-1:0] vga_x,
    input  logic [CNT_W-1:0] vga_y,
    output logic             wr_memory_fg,
    output logic             memory_fg_selector,
    output logic             wr_register,
    output logic             registers_reset,
    output logic             reset_counter_x,
    output logic [IA_W-1:0]  register_w_address,
    output logic [RA_W-1:0]  register_r_address,
    output logic [IA_W-1:0]  memory_read_address,
    output logic             load_done,
    output logic             frame_done
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    state_e          state_q, state_d;
    ctrl_t           ctrl_q;
    logic [IA_W-1:0] addr_q, addr_d;
    logic            host_req;
    logic            in_window;
    logic            lane_clear, lane_enable;

    // Host may only reclaim the memory before the last line of the frame.
    assign host_req  = !printtingScreen && (vga_y < CNT_W'(V_LAST));
    assign in_window = (vga_x >= CNT_W'(H_START)) && (vga_x < CNT_W'(H_ACTIVE));

    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        case (state_q)
            StReset:      state_d = StStepReset;
            StStepReset:  state_d = StReadMemory;
            StReadMemory: begin
                state_d = StUploadData;
                addr_d  = addr_q;
            end
            StUploadData: begin
                if (addr_q == IA_W'(INST_DEPTH - 1)) begin
                    state_d = StStepProcessing;
                end else begin
                    state_d = StReadMemory;
                    addr_d  = addr_q + 1'b1;
                end
            end
            StStepProcessing: state_d = StProcessing;
            StProcessing: begin
                if (host_req) begin
                    state_d = StRefreshInstMemory;
                end else if (!hold && (counter_x >= CNT_W'(H_ACTIVE))) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (host_req) begin
                    state_d = StRefreshInstMemory;
                end else if (in_window) begin
                    state_d = StProcessing;
                end
            end
            StRefreshInstMemory: begin
                if (vga_y >= CNT_W'(V_LAST)) begin
                    state_d = StReset;
                end
            end
            default: state_d = StReset;
        endcase
    end

    // The lane only advances while staying in PROCESSING; any other destination zeroes it.
    assign lane_clear  = (state_d != StProcessing);
    assign lane_enable = (state_q == StProcessing) && (state_d == StProcessing);

    lane_counter #(
        .NUM_LANES (NUM_LANES)
    ) u_lane_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (lane_clear),
        .hold   (hold),
        .enable (lane_enable),
        .count  (register_r_address)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StReset;
            ctrl_q     <= CtrlReset;
            addr_q     <= '0;
            load_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_of(state_d);
            addr_q     <= addr_d;
            load_done  <= (state_d == StStepProcessing);
            frame_done <= (state_q == StRefreshInstMemory) && (state_d == StReset);
        end
    end

`ifdef FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if ((state_q == StRefreshInstMemory) && (state_d == StReset)) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

    assign wr_memory_fg        = ctrl_q.wr_memory_fg;
    assign memory_fg_selector  = ctrl_q.memory_fg_selector;
    assign wr_register         = ctrl_q.wr_register;
    assign registers_reset     = ctrl_q.registers_reset;
    assign reset_counter_x     = ctrl_q.reset_counter_x;
    assign register_w_address  = addr_q;
    assign memory_read_address = addr_q;

endmodule

// File: doc/controls_pipeline_gen2.md
Name:
controls_pipeline_gen2

Overview:
- Parametrised successor of the co-processor control sequencer.
- Per frame: resets the register banks, then copies every instruction-memory word into the register banks, then steps the register-bank read address across lanes for each active VGA line.
- Returns the instruction memory to host-write mode during vertical blanking.
- Adds parametrised depth, lane count and timing, a processing hold, a WAIT-to-refresh exit, and status pulses.

Parameters:
INST_DEPTH, 16, instruction-memory words loaded per frame (>=2)
NUM_LANES, 4, register-bank read lanes cycled during processing (>=2, any value, not only powers of 2)
H_START, 10, first vga_x at which processing may start
H_ACTIVE, 640, active pixels per line; bound for counter_x and vga_x
V_LAST, 523, vga_y value that starts a new frame load
CNT_W, 10, width of counter_x/vga_x/vga_y
(derived) IA_W = clog2(INST_DEPTH), RA_W = clog2(NUM_LANES)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
printtingScreen  in  1  1 = frame active, 0 = host wants memory access
hold  in  1  freezes lane stepping in PROCESSING
counter_x  in  CNT_W  processed-pixel counter
vga_x  in  CNT_W  VGA x coordinate
vga_y  in  CNT_W  VGA y coordinate
wr_memory_fg  out  1  1 = instruction memory write mode
memory_fg_selector  out  1  0 = host write address, 1 = sequencer read address
wr_register  out  1  register-bank write strobe
registers_reset  out  1  active-low register-bank reset
reset_counter_x  out  1  active-low counter_x reset
register_w_address  out  IA_W  register-bank write address
register_r_address  out  RA_W  register-bank read lane
memory_read_address  out  IA_W  instruction-memory read address
load_done  out  1  one-cycle pulse when the load completes
frame_done  out  1  one-cycle pulse on REFRESH_INST_MEMORY->RESET

Behaviour:
- State register and all outputs are registered on posedge clk; outputs always reflect the current state (no negedge logic).
- Reset: synchronous reset=1 forces state RESET and all outputs 0 on the next edge, including mid-load or mid-line. Reset has priority over every transition.
- State sequence and outputs (wr_memory_fg/selector/wr_register/registers_reset/reset_counter_x):
  - RESET 0/0/0/0/0, 1 cycle -> STEP_RESET.
  - STEP_RESET 0/1/0/1/0, 1 cycle -> READ_MEMORY.
  - READ_MEMORY 0/1/0/1/0, 1 cycle -> UPLOAD_DATA.
  - UPLOAD_DATA 0/1/1/1/0. register_w_address equals memory_read_address. If address == INST_DEPTH-1 -> STEP_PROCESSING; else increment both addresses -> READ_MEMORY.
  - STEP_PROCESSING 0/1/0/1/0, load_done=1, addresses cleared -> PROCESSING.
  - PROCESSING 0/1/0/1/1. Priority order:
    1. (printtingScreen==0 && vga_y<V_LAST) -> REFRESH_INST_MEMORY.
    2. hold=1 -> stay, r_address frozen.
    3. counter_x<H_ACTIVE -> stay, r_address increments, wrapping NUM_LANES-1 -> 0.
    4. Otherwise -> WAIT with r_address cleared.
  - WAIT 0/1/0/1/0. (printtingScreen==0 && vga_y<V_LAST) -> REFRESH_INST_MEMORY; else H_START<=vga_x<H_ACTIVE -> PROCESSING; else stay.
  - REFRESH_INST_MEMORY 1/0/0/0/0. vga_y>=V_LAST -> RESET with frame_done=1; else stay.
- Load latency: the k-th write (k=0..INST_DEPTH-1) occurs at cycle 3+2k after reset release. load_done at cycle 2+2*INST_DEPTH; PROCESSING at cycle 3+2*INST_DEPTH.
- Illegal state encodings -> RESET.
- Address arithmetic is unsigned modulo field width; addresses never exceed INST_DEPTH-1 or NUM_LANES-1.

Optional Feature:
FRAME_CNT_EN:
- Defined: adds output frame_count [15:0]. It is cleared by reset and incremented on every frame_done, wrapping at 0xFFFF -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package controls_pipeline_pkg holds:
  - the 3-bit state encodings (RESET=0, WAIT=1, UPLOAD_DATA=2, READ_MEMORY=3, PROCESSING=4, REFRESH_INST_MEMORY=5, STEP_RESET=6, STEP_PROCESSING=7);
  - the clog2 function;
  - the control-output bundle constants per state.
- One sub-module, lane_counter: modulo-NUM_LANES counter with clear, hold and enable, used for register_r_address.

Test Plan:
1. Reset held 2 cycles then released, INST_DEPTH=16 -> wr_register pulses at cycles 3,5,...,33 with w_address 0..15; load_done at cycle 34; reset_counter_x=1 from cycle 35.
2. NUM_LANES=3, PROCESSING, counter_x<640 for 7 cycles -> register_r_address 0,1,2,0,1,2,0.
3. hold=1 for 3 cycles at r_address=2 -> stays 2; after release -> 0.
4. counter_x=640 -> WAIT, r_address=0; vga_x=5 -> remains WAIT; vga_x=10 -> PROCESSING next cycle.
5. printtingScreen=0 at vga_y=480 in WAIT -> wr_memory_fg=1, selector=0, registers_reset=0; vga_y=523 -> RESET with frame_done=1, then full reload (with FRAME_CNT_EN: frame_count 0->1).
6. reset=1 at cycle 20 of load -> next cycle state RESET, all outputs 0, addresses 0; after release the load restarts from address 0.
